// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_READ_LAT = 4;

  // Widest data word the lane-merge helper handles. Callers zero-extend.
  localparam int MAX_W = 64;

  // Byte-lane merge: lanes with an enable bit take the new data, the others
  // keep the old word. byte_w is a constant at every call site, so the
  // division folds away.
  function automatic logic [MAX_W-1:0] merge_lanes(
    input logic [MAX_W-1:0] old_word,
    input logic [MAX_W-1:0] new_word,
    input logic [MAX_W-1:0] byteen,
    input int               byte_w
  );
    logic [MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_W; i++) begin
      if (byteen[i / byte_w]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between load/store control and the data memory.
interface dmem_if #(
  parameter int DATA_W = 24,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 24
) ();

  logic                       Req;
  logic                       Ready;
  logic                       MemWrite;
  logic                       MemRead;
  logic [ADDR_W-1:0]          Address;
  logic [DATA_W-1:0]          WriteData;
  logic [DATA_W/BYTE_W-1:0]   ByteEn;
  logic [DATA_W-1:0]          ReadData;
  logic                       ReadValid;
  logic                       Error;

  modport master (
    output Req, MemWrite, MemRead, Address, WriteData, ByteEn,
    input  Ready, ReadData, ReadValid, Error
  );

  modport slave (
    input  Req, MemWrite, MemRead, Address, WriteData, ByteEn,
    output Ready, ReadData, ReadValid, Error
  );

endinterface

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency response pipeline: carries each accepted read/fault response
// READ_LAT cycles and holds the last read data between responses.
module dmem_resp_pipe #(
  parameter int DATA_W   = 24,
  parameter int READ_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              push_valid,
  input  logic              push_read,
  input  logic              push_error,
  input  logic [DATA_W-1:0] push_data,
  output logic              read_valid,
  output logic              error,
  output logic [DATA_W-1:0] read_data
);

  logic              vld_p  [READ_LAT];
  logic              rd_p   [READ_LAT];
  logic              err_p  [READ_LAT];
  logic [DATA_W-1:0] data_p [READ_LAT];
  logic [DATA_W-1:0] hold;

  // Valid bits shift every cycle; reset drops everything in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= push_valid;
      for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Payload shifts alongside valid; only meaningful where valid is set.
  always_ff @(posedge Clock) begin
    rd_p[0]   <= push_read;
    err_p[0]  <= push_error;
    data_p[0] <= push_data;
    for (int i = 1; i < READ_LAT; i++) begin
      rd_p[i]   <= rd_p[i-1];
      err_p[i]  <= err_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  // Remember the last delivered read word so ReadData is stable between pulses.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) hold <= '0;
    else if (read_valid) hold <= data_p[READ_LAT-1];
  end

  assign read_valid = vld_p[READ_LAT-1] & rd_p[READ_LAT-1];
  assign error      = vld_p[READ_LAT-1] & err_p[READ_LAT-1];
  assign read_data  = read_valid ? data_p[READ_LAT-1] : hold;

endmodule

// File: rtl/data_memory_pipe.sv
// Word-addressed data memory with byte-lane writes, fixed read latency,
// range/conflict fault reporting and a hardware zero-init sweep.
module data_memory_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 24,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2
) (
  input  logic  Clock,
  input  logic  Reset_n,
  input  logic  Clear,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, in_range, fault, wr_ok, rd_ok;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] merged;

  assign bus.Ready = (state == RUN);
  assign accept    = bus.Req & bus.Ready;
  // Any set bit above the index field means the word lies beyond DEPTH.
  assign in_range  = ((bus.Address >> IDX_W) == '0);
  assign fault     = accept & (~in_range | (bus.MemWrite & bus.MemRead));
  assign wr_ok     = accept & bus.MemWrite & ~bus.MemRead & in_range;
  assign rd_ok     = accept & bus.MemRead & ~bus.MemWrite & in_range;
  assign word_idx  = bus.Address[IDX_W-1:0];
  assign merged    = DATA_W'(merge_lanes(MAX_W'(mem[word_idx]), MAX_W'(bus.WriteData),
                                         MAX_W'(bus.ByteEn), BYTE_W));

  // State and sweep index registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Sweep every word once, then serve requests until Clear restarts the sweep.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      INIT: begin
        idx_next = idx + 1'b1;
        if (idx == IDX_W'(DEPTH - 1)) state_next = RUN;
      end
      RUN: begin
        if (Clear) begin
          state_next = INIT;
          idx_next   = '0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Array port: sweep zeros during INIT, otherwise commit accepted writes.
  always_ff @(posedge Clock) begin
    if (state == INIT) mem[idx] <= '0;
    else if (wr_ok) mem[word_idx] <= merged;
  end

  dmem_resp_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_resp (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .push_valid (accept & (bus.MemRead | fault)),
    .push_read  (bus.MemRead),
    .push_error (fault),
    .push_data  (rd_ok ? mem[word_idx] : '0),
    .read_valid (bus.ReadValid),
    .error      (bus.Error),
    .read_data  (bus.ReadData)
  );

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench for data_memory_pipe: directed scenarios plus random traffic
// against an array-based reference model.
module tb_data_memory_pipe;

  localparam int DATA_W   = 24;
  localparam int BYTE_W   = 8;
  localparam int ADDR_W   = 24;
  localparam int DEPTH    = 256;
  localparam int READ_LAT = 2;
  localparam int LANES    = DATA_W / BYTE_W;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;
  logic Clear   = 1'b0;

  dmem_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

  data_memory_pipe #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Clear   (Clear),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    bit          rv;
    bit          err;
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] model_mem [DEPTH];
  logic [23:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop expected responses as the DUT presents them.
  always @(negedge Clock) begin
    if (Reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_response due=%0d now=%0d", exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.ReadValid || bus.Error) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response rv=%0b err=%0b data=%0h cycle=%0d",
                   bus.ReadValid, bus.Error, bus.ReadData, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_cycle", cyc, mon_e.due);
          chk("read_valid", bus.ReadValid, mon_e.rv);
          chk("error", bus.Error, mon_e.err);
          if (mon_e.rv) begin
            chk("read_data", bus.ReadData, mon_e.data);
            last_rd = mon_e.data;
          end else begin
            chk("read_data_hold", bus.ReadData, last_rd);
          end
        end
      end else begin
        chk("read_data_hold", bus.ReadData, last_rd);
      end
    end
  end

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // One request cycle; the model predicts acceptance from Ready.
  task automatic req(input bit w, input bit r, input logic [23:0] addr,
                     input logic [23:0] data, input logic [LANES-1:0] be,
                     input bit clr);
    bit acc, flt;
    bus.Req       = 1'b1;
    bus.MemWrite  = w;
    bus.MemRead   = r;
    bus.Address   = addr;
    bus.WriteData = data;
    bus.ByteEn    = be;
    Clear         = clr;
    acc = bus.Ready;
    flt = (addr >= DEPTH) || (w && r);
    if (acc) begin
      if (r || flt)
        exp_q.push_back('{rv: r, err: flt,
                          data: (r && !flt) ? model_mem[addr[7:0]] : 24'h0,
                          due: cyc + READ_LAT});
      if (w && !flt)
        for (int i = 0; i < LANES; i++)
          if (be[i]) model_mem[addr[7:0]][i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
    end
    @(posedge Clock);
    #1;
    bus.Req      = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    Clear        = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.Req = 1'b0;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Count cycles with Ready low, bounded; the sweep must take DEPTH cycles.
  task automatic count_init(input string name);
    int n;
    n = 0;
    while (!bus.Ready && n < 1000) begin
      n++;
      @(posedge Clock);
      #1;
    end
    chk(name, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req       = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.ByteEn    = '0;
    #2 Reset_n = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    chk("reset_ready", bus.Ready, 0);
    chk("reset_read_valid", bus.ReadValid, 0);
    chk("reset_error", bus.Error, 0);
    chk("reset_read_data", bus.ReadData, 0);
    Reset_n = 1'b1;
    model_zero();
    count_init("init_cycles");

    // Scenario 1: swept word reads back as zero.
    req(0, 1, 24'd5, 24'h0, 3'b000, 0);
    idle(3);

    // Scenario 2: write then read next cycle.
    req(1, 0, 24'd2, 24'd10, 3'b111, 0);
    req(0, 1, 24'd2, 24'h0, 3'b000, 0);
    idle(3);

    // Scenario 3: partial lane write.
    req(1, 0, 24'd7, 24'hAABBCC, 3'b111, 0);
    req(1, 0, 24'd7, 24'h112233, 3'b010, 0);
    req(0, 1, 24'd7, 24'h0, 3'b000, 0);
    idle(3);

    // Scenario 4: faults.
    req(1, 0, 24'd300, 24'h000123, 3'b111, 0);
    idle(3);
    req(0, 1, 24'd300, 24'h0, 3'b000, 0);
    idle(3);
    req(1, 1, 24'd2, 24'h00FFFF, 3'b111, 0);
    req(0, 1, 24'd2, 24'h0, 3'b000, 0);
    req(0, 1, 24'hFFFFFF, 24'h0, 3'b000, 0);
    req(0, 0, 24'd3, 24'h0, 3'b111, 0);
    idle(3);

    // Scenario 5: back-to-back reads.
    req(1, 0, 24'd1, 24'h1, 3'b111, 0);
    req(1, 0, 24'd2, 24'h2, 3'b111, 0);
    req(1, 0, 24'd3, 24'h3, 3'b111, 0);
    req(0, 1, 24'd1, 24'h0, 3'b000, 0);
    req(0, 1, 24'd2, 24'h0, 3'b000, 0);
    req(0, 1, 24'd3, 24'h0, 3'b000, 0);
    idle(4);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      int          op;
      logic [23:0] a;
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        op = $urandom_range(0, 7);
        if ($urandom_range(0, 9) == 0) a = 24'(256 + $urandom_range(0, 1000));
        else a = 24'($urandom_range(0, 15));
        case (op)
          0, 1, 2: req(0, 1, a, 24'h0, 3'b000, 0);
          3, 4, 5: req(1, 0, a, 24'($urandom), 3'($urandom), 0);
          6:       req(1, 1, a, 24'($urandom), 3'b111, 0);
          default: req(0, 0, a, 24'($urandom), 3'($urandom), 0);
        endcase
      end
    end
    idle(4);

    // Scenario 6a: reset with two reads in flight.
    req(0, 1, 24'd1, 24'h0, 3'b000, 0);
    req(0, 1, 24'd2, 24'h0, 3'b000, 0);
    Reset_n = 1'b0;
    #1;
    chk("midreset_read_valid", bus.ReadValid, 0);
    chk("midreset_error", bus.Error, 0);
    chk("midreset_ready", bus.Ready, 0);
    chk("midreset_read_data", bus.ReadData, 0);
    exp_q.delete();
    last_rd = '0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    model_zero();
    count_init("reinit_cycles");
    req(0, 1, 24'd7, 24'h0, 3'b000, 0);
    idle(3);

    // Scenario 6b: Clear in RUN, with a read accepted in the same cycle.
    req(1, 0, 24'd7, 24'h5A5A5A, 3'b111, 0);
    req(0, 1, 24'd7, 24'h0, 3'b000, 1);
    model_zero();
    count_init("clear_init_cycles");
    req(0, 1, 24'd7, 24'h0, 3'b000, 0);
    idle(6);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised successor of the CPU data memory. Word-addressed synchronous RAM with a request/ready handshake, byte-lane write enables, configurable read latency, address-range error reporting, and a hardware zero-initialisation sweep after reset or on demand. Sits between the MEM stage of the 24-bit datapath and the load/store control, replacing the fixed single-port memory.

Parameters:
DATA_W, 24, data word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, width of one write-enable lane
ADDR_W, 24, width of the Address port
DEPTH, 256, number of words; power of two, DEPTH <= 2**ADDR_W
READ_LAT, 2, cycles from read acceptance to ReadValid; legal range 1..4

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
Clear  in  1  one-cycle pulse; restarts the zero-init sweep (ignored during INIT)
Req  in  1  request valid
Ready  out  1  block can accept a request this cycle
MemWrite  in  1  request is a write
MemRead  in  1  request is a read
Address  in  ADDR_W  word address
WriteData  in  DATA_W  write data
ByteEn  in  DATA_W/BYTE_W  per-lane write enable; bit i covers WriteData[i*BYTE_W +: BYTE_W]
ReadData  out  DATA_W  read data; holds the last value between responses
ReadValid  out  1  one-cycle pulse, ReadData valid
Error  out  1  one-cycle pulse, faulting request response

Behaviour:
- Reset (Reset_n=0, asynchronous): Ready=0, ReadValid=0, Error=0, ReadData=0, response pipeline flushed, state=INIT, sweep index=0. Array contents are not reset directly.
- FSM, two states:
  - INIT: writes 0 to word[idx] each cycle, idx 0..DEPTH-1. Ready=0. Req is ignored. After writing word DEPTH-1, go to RUN. Lasts exactly DEPTH cycles after reset deassertion.
  - RUN: Ready=1. A Clear pulse goes to INIT with idx=0. Ready falls the next cycle. A request accepted in the Clear cycle is still processed.
- Accept = Req & Ready. One request per cycle max. No back-pressure in RUN.
- Fault conditions: Address >= DEPTH, or MemWrite & MemRead both high.
- Write accepted, no fault: on the same clock edge, each lane with ByteEn[i]=1 is written. Lanes with ByteEn[i]=0 keep their old value. No ReadValid is produced. ByteEn=0 is a legal no-op.
- Read accepted, no fault: the array is sampled on the accept edge. ReadValid=1 and ReadData=word appear exactly READ_LAT cycles after the accept cycle.
- Fault: the memory is never modified. Error pulses READ_LAT cycles after acceptance. If MemRead=1, ReadValid pulses in the same cycle with ReadData=0.
- Req with MemRead=MemWrite=0: accepted, no effect, no response.
- Ordering: responses come back in acceptance order. Back-to-back reads give ReadValid on consecutive cycles.
- Hazards: a read accepted the cycle after a write to the same word returns the new data, because the write committed on the earlier edge. No forwarding path is needed.
- Index is Address[$clog2(DEPTH)-1:0], used only after the range check passes.
- Reset mid-operation: in-flight responses are dropped and never emitted. INIT restarts from 0.
- Clear while reads are in flight: pending responses still emit with data sampled at acceptance.

Decomposition:
- Package dmem_pkg:
  - state enum {INIT, RUN}
  - MAX_READ_LAT=4
  - function merge_lanes(old, new, byteen), returning the byte-lane merged word
- Sub-module dmem_resp_pipe: READ_LAT-deep shift register carrying {valid, is_read, error, data}. Asynchronously cleared by Reset_n. Drives ReadValid, Error and ReadData.

Test Plan:
All scenarios use defaults: DATA_W=24, DEPTH=256, READ_LAT=2.
1. Release Reset_n, count cycles -> Ready=0 for exactly 256 cycles, then 1. Read Address=5 -> ReadValid 2 cycles later with ReadData=24'h000000, Error=0.
2. Write Address=2, WriteData=24'd10, ByteEn=3'b111, then read Address=2 on the next cycle -> ReadValid at read-accept+2 with ReadData=24'd10.
3. Write Address=7 with 24'hAABBCC, ByteEn=3'b111. Then write 24'h112233 with ByteEn=3'b010. Then read 7 -> ReadData=24'hAA22CC.
4. Write Address=300 with 24'h000123 -> Error pulse at +2, no ReadValid. Read Address=300 -> ReadValid=1, Error=1, ReadData=0. A request with MemRead=MemWrite=1 at Address=2 -> Error, and word 2 is still 24'd10.
5. Reads of addresses 1, 2, 3 accepted on three consecutive cycles (preloaded 24'h1, 24'h2, 24'h3) -> ReadValid high for 3 consecutive cycles with data 1, 2, 3 in order.
6. Assert Reset_n=0 with two reads in flight -> ReadValid/Error/Ready drop to 0 immediately, no stale pulse after release, and INIT runs 256 cycles. Separately, pulse Clear in RUN -> Ready=0 for 256 cycles, then a read of word 7 returns 0.
